// File: rtl/sensor_frame_feeder.sv
// ---------------------------------------------------------------------------
// sensor_frame_feeder
//   Serial front-end for the fuzzy risk estimator. It hunts a bit stream for a
//   sync byte, then collects a positional rain byte, a soil byte and an XOR
//   checksum byte. Frames that pass the checksum are clamped to 0..MAX_VAL and
//   presented on raw/sow. The ef output stays high for TIMEOUT_CYC clocks after
//   the last good frame. Checksum failures are counted in err_cnt, which
//   saturates at 255.
//
//   Optional feature macro: SENSOR_AVG_EN
//     defined   : raw/sow are the 4-frame moving average of clamped values.
//     undefined : raw/sow are the clamped values of the latest good frame.
//
//   Reset: rst_n is synchronous and active-low.
// ---------------------------------------------------------------------------
module sensor_frame_feeder #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_VAL     = 100,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] raw,
  output logic [7:0] sow,
  output logic       ef,
  output logic       frame_stb,
  output logic [7:0] err_cnt
);

  localparam int             CW          = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]  TIMEOUT_LIM = CW'(TIMEOUT_CYC);
  localparam logic [7:0]     MAX_B       = 8'(MAX_VAL);

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_RAIN = 2'd1,
    ST_SOIL = 2'd2,
    ST_CHK  = 2'd3
  } state_t;

  // Limit a received byte to the legal sensor range.
  function automatic logic [7:0] clamp_val(input logic [7:0] v);
    if (v > MAX_B) begin
      return MAX_B;
    end else begin
      return v;
    end
  endfunction

  // Frame checksum: XOR of the unclamped rain and soil bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] a, input logic [7:0] b);
    return a ^ b;
  endfunction

  // Mean of four samples using a 10-bit sum; the remainder is truncated.
  function automatic logic [7:0] avg4(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    logic [9:0] sum;
    sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return sum[9:2];
  endfunction

  state_t          state_r, state_nxt_s;
  logic [7:0]      shift_r, shift_nxt_s, shifted_s;
  logic [2:0]      bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0]      rain_r, rain_nxt_s;
  logic [7:0]      soil_r, soil_nxt_s;
  logic            good_s, bad_s;
  logic [7:0]      rain_cl_s, soil_cl_s;
  logic [7:0]      raw_r, sow_r, err_cnt_r;
  logic            ef_r, frame_stb_r;
  logic [CW-1:0]   tmo_cnt_r, tmo_inc_s;

  assign shifted_s = {shift_r[6:0], bit_in};
  assign rain_cl_s = clamp_val(rain_r);
  assign soil_cl_s = clamp_val(soil_r);
  assign tmo_inc_s = tmo_cnt_r + {{(CW-1){1'b0}}, 1'b1};

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_HUNT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: sliding sync search, then three positional 8-bit fields.
  // The window is cleared whenever a field completes so a finished checksum
  // byte can never be taken as the next sync byte.
  always_comb begin
    state_nxt_s   = state_r;
    shift_nxt_s   = shift_r;
    bit_cnt_nxt_s = bit_cnt_r;
    rain_nxt_s    = rain_r;
    soil_nxt_s    = soil_r;
    good_s        = 1'b0;
    bad_s         = 1'b0;
    if (bit_valid) begin
      case (state_r)
        ST_HUNT: begin
          if (shifted_s == SYNC_BYTE) begin
            state_nxt_s   = ST_RAIN;
            shift_nxt_s   = 8'h00;
            bit_cnt_nxt_s = 3'd0;
          end else begin
            shift_nxt_s   = shifted_s;
          end
        end
        ST_RAIN: begin
          if (bit_cnt_r == 3'd7) begin
            rain_nxt_s    = shifted_s;
            state_nxt_s   = ST_SOIL;
            shift_nxt_s   = 8'h00;
            bit_cnt_nxt_s = 3'd0;
          end else begin
            shift_nxt_s   = shifted_s;
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          end
        end
        ST_SOIL: begin
          if (bit_cnt_r == 3'd7) begin
            soil_nxt_s    = shifted_s;
            state_nxt_s   = ST_CHK;
            shift_nxt_s   = 8'h00;
            bit_cnt_nxt_s = 3'd0;
          end else begin
            shift_nxt_s   = shifted_s;
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          end
        end
        ST_CHK: begin
          if (bit_cnt_r == 3'd7) begin
            if (shifted_s == frame_chk(rain_r, soil_r)) begin
              good_s = 1'b1;
            end else begin
              bad_s  = 1'b1;
            end
            state_nxt_s   = ST_HUNT;
            shift_nxt_s   = 8'h00;
            bit_cnt_nxt_s = 3'd0;
          end else begin
            shift_nxt_s   = shifted_s;
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          end
        end
        default: begin
          state_nxt_s   = ST_HUNT;
          shift_nxt_s   = 8'h00;
          bit_cnt_nxt_s = 3'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Deserializer registers: shift window, bit counter and captured fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
      rain_r    <= 8'h00;
      soil_r    <= 8'h00;
    end else begin
      shift_r   <= shift_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      rain_r    <= rain_nxt_s;
      soil_r    <= soil_nxt_s;
    end
  end

  // Freshness: a good frame re-arms ef; otherwise count down its lifetime and
  // hold the counter once ef has dropped. A good frame beats expiry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ef_r        <= 1'b0;
      tmo_cnt_r   <= {CW{1'b0}};
      frame_stb_r <= 1'b0;
    end else if (good_s) begin
      ef_r        <= 1'b1;
      tmo_cnt_r   <= {CW{1'b0}};
      frame_stb_r <= 1'b1;
    end else begin
      frame_stb_r <= 1'b0;
      if (ef_r) begin
        tmo_cnt_r <= tmo_inc_s;
        if (tmo_inc_s == TIMEOUT_LIM) begin
          ef_r <= 1'b0;
        end
      end
    end
  end

  // Checksum failure counter, saturating at 255.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_r <= 8'h00;
    end else if (bad_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'h01;
    end
  end

`ifdef SENSOR_AVG_EN
  // Three previous clamped samples per channel; together with the sample being
  // accepted they form the 4-deep averaging history (index 0 is most recent).
  logic [7:0] rain_h_r [3];
  logic [7:0] soil_h_r [3];

  // Averaged outputs: shift history and publish the mean on each good frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raw_r <= 8'h00;
      sow_r <= 8'h00;
      for (int i = 0; i < 3; i++) begin
        rain_h_r[i] <= 8'h00;
        soil_h_r[i] <= 8'h00;
      end
    end else if (good_s) begin
      raw_r       <= avg4(rain_cl_s, rain_h_r[0], rain_h_r[1], rain_h_r[2]);
      sow_r       <= avg4(soil_cl_s, soil_h_r[0], soil_h_r[1], soil_h_r[2]);
      rain_h_r[0] <= rain_cl_s;
      rain_h_r[1] <= rain_h_r[0];
      rain_h_r[2] <= rain_h_r[1];
      soil_h_r[0] <= soil_cl_s;
      soil_h_r[1] <= soil_h_r[0];
      soil_h_r[2] <= soil_h_r[1];
    end
  end
`else
  // Direct outputs: publish the clamped values of each good frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raw_r <= 8'h00;
      sow_r <= 8'h00;
    end else if (good_s) begin
      raw_r <= rain_cl_s;
      sow_r <= soil_cl_s;
    end
  end
`endif

  assign raw       = raw_r;
  assign sow       = sow_r;
  assign ef        = ef_r;
  assign frame_stb = frame_stb_r;
  assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_sensor_frame_feeder.sv
// ---------------------------------------------------------------------------
// tb_sensor_frame_feeder
//   Directed self-checking bench for sensor_frame_feeder with TIMEOUT_CYC=50.
//   Expected values are hand-computed for both builds (SENSOR_AVG_EN on/off).
// ---------------------------------------------------------------------------
module tb_sensor_frame_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic [7:0] raw, sow, err_cnt;
  logic       ef, frame_stb;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SENSOR_AVG_EN
  // history starts at zero: (50)/4=12, (20)/4=5; (100+50)/4=37, (80+20)/4=25;
  // (10+100+50)/4=40, (11+80+20)/4=27
  localparam int E2R = 12, E2S = 5, E4R = 37, E4S = 25, E5R = 40, E5S = 27;
  localparam int E6_0 = 25, E6_1 = 50, E6_2 = 75, E6_3 = 100, E7 = 25;
`else
  localparam int E2R = 50, E2S = 20, E4R = 100, E4S = 80, E5R = 10, E5S = 11;
  localparam int E6_0 = 100, E6_1 = 100, E6_2 = 100, E6_3 = 100, E7 = 100;
`endif

  sensor_frame_feeder #(
    .SYNC_BYTE  (8'hA5),
    .MAX_VAL    (100),
    .TIMEOUT_CYC(50)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_valid(bit_valid),
    .bit_in   (bit_in),
    .raw      (raw),
    .sow      (sow),
    .ef       (ef),
    .frame_stb(frame_stb),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) tick();
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    for (int i = 7; i >= 0; i--) send_bit(b[i], max_gap);
  endtask

  task automatic send_frame(input logic [7:0] r, input logic [7:0] s,
                            input logic [7:0] c, input int max_gap);
    send_byte(8'hA5, max_gap);
    send_byte(r, max_gap);
    send_byte(s, max_gap);
    send_byte(c, max_gap);
  endtask

  task automatic check_outs(input string tag, input int er, input int es,
                            input int eef, input int estb, input int eerr);
    check_val({tag, "_raw"}, {24'd0, raw}, er);
    check_val({tag, "_sow"}, {24'd0, sow}, es);
    check_val({tag, "_ef"}, {31'd0, ef}, eef);
    check_val({tag, "_stb"}, {31'd0, frame_stb}, estb);
    check_val({tag, "_err"}, {24'd0, err_cnt}, eerr);
  endtask

  initial begin
    logic [12:0] garbage;
    garbage = 13'b1111000011110;

    // 1 reset
    rst_n = 1'b0;
    repeat (3) tick();
    check_outs("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // 2 good frame
    send_frame(8'h32, 8'h14, 8'h26, 0);
    check_outs("good", E2R, E2S, 1, 1, 0);
    tick();
    check_val("good_stb_one_cycle", {31'd0, frame_stb}, 0);

    // 3 bad checksum
    send_frame(8'h32, 8'h14, 8'h00, 0);
    check_outs("badchk", E2R, E2S, 1, 0, 1);

    // 4 clamp (C8^50=98)
    send_frame(8'hC8, 8'h50, 8'h98, 0);
    check_outs("clamp", E4R, E4S, 1, 1, 1);

    // 5 hunt through garbage with gaps, then timeout
    for (int i = 12; i >= 0; i--) send_bit(garbage[i], 2);
    send_frame(8'h0A, 8'h0B, 8'h01, 2);
    check_outs("hunt", E5R, E5S, 1, 1, 1);
    repeat (49) tick();
    check_val("tmo_ef_before", {31'd0, ef}, 1);
    tick();
    check_val("tmo_ef_after", {31'd0, ef}, 0);
    check_val("tmo_raw_kept", {24'd0, raw}, E5R);
    check_val("tmo_sow_kept", {24'd0, sow}, E5S);
    repeat (5) tick();
    check_val("tmo_ef_held", {31'd0, ef}, 0);

    // error counter saturation: 1 + 254 -> 255, one more stays 255
    repeat (254) send_frame(8'h01, 8'h02, 8'h00, 0);
    check_val("err_255", {24'd0, err_cnt}, 255);
    send_frame(8'h01, 8'h02, 8'h00, 0);
    check_val("err_sat", {24'd0, err_cnt}, 255);
    check_val("err_sat_raw", {24'd0, raw}, E5R);

    // 6 averaging ramp (or plain 100 per frame) from a clean reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send_frame(8'h64, 8'h64, 8'h00, 0);
    check_outs("ramp0", E6_0, E6_0, 1, 1, 0);
    send_frame(8'h64, 8'h64, 8'h00, 0);
    check_outs("ramp1", E6_1, E6_1, 1, 1, 0);
    send_frame(8'h64, 8'h64, 8'h00, 0);
    check_outs("ramp2", E6_2, E6_2, 1, 1, 0);
    send_frame(8'h64, 8'h64, 8'h00, 0);
    check_outs("ramp3", E6_3, E6_3, 1, 1, 0);

    // reset mid-frame discards the partial frame and history
    send_byte(8'hA5, 0);
    send_byte(8'h64, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_outs("midrst", 0, 0, 0, 0, 0);
    send_byte(8'h64, 0);
    send_byte(8'h00, 0);
    check_val("midrst_tail_ef", {31'd0, ef}, 0);
    send_frame(8'h64, 8'h64, 8'h00, 0);
    check_outs("after_rst", E7, E7, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
